// File: rtl/writeback_queue.sv
// writeback_queue
//   In-order write-back buffer that sits in front of the register file's single
//   write port. Load-return (mem) and ALU write-backs are collected into a small
//   circular FIFO and drained one entry per cycle. Read-after-write hazards are
//   reported for the two regfile read addresses.
//
// Optional feature macro: WBQ_FORWARD_EN
//   defined     : per read port, forward the data of the youngest pending entry
//                 whose address matches; hazard_o is held at 0.
//   not defined : forwarding outputs tied to 0; hazard_o reports pending matches.
//
// Ports
//   clk, reset_n_i             clock (rising edge), asynchronous active-low reset
//   mem_valid_i/addr_i/data_i  load-return write-back request
//   alu_valid_i/addr_i/data_i  ALU write-back request (younger than mem when both)
//   rd_addr_1_i, rd_addr_2_i   regfile read addresses for hazard/forward lookup
//   wr_en_o/addr_o/data_o      regfile write port (head of queue)
//   full_o                     fewer than 2 free entries
//   hazard_o                   a nonzero read address matches a pending entry
//   overflow_o                 sticky: a request was dropped for lack of space
//   count_o                    occupied entries
//   fwd_hit_n_o, fwd_data_n_o  forwarding result per read port
module writeback_queue #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                         clk,
    input  logic                         reset_n_i,
    input  logic                         mem_valid_i,
    input  logic [ADDR_WIDTH-1:0]        mem_addr_i,
    input  logic [DATA_WIDTH-1:0]        mem_data_i,
    input  logic                         alu_valid_i,
    input  logic [ADDR_WIDTH-1:0]        alu_addr_i,
    input  logic [DATA_WIDTH-1:0]        alu_data_i,
    input  logic [ADDR_WIDTH-1:0]        rd_addr_1_i,
    input  logic [ADDR_WIDTH-1:0]        rd_addr_2_i,
    output logic                         wr_en_o,
    output logic [ADDR_WIDTH-1:0]        wr_addr_o,
    output logic [DATA_WIDTH-1:0]        wr_data_o,
    output logic                         full_o,
    output logic                         hazard_o,
    output logic                         overflow_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         fwd_hit_1_o,
    output logic                         fwd_hit_2_o,
    output logic [DATA_WIDTH-1:0]        fwd_data_1_o,
    output logic [DATA_WIDTH-1:0]        fwd_data_2_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]      r_vld;
    logic [PW-1:0]         r_head;
    logic [PW-1:0]         r_tail;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;

    logic                  w_pop;
    logic [CW:0]           w_free;
    logic                  w_mem_req;
    logic                  w_alu_req;
    logic                  w_mem_acc;
    logic                  w_alu_acc;
    logic                  w_refuse;
    logic [PW-1:0]         w_alu_slot;
    logic                  w_hit_1;
    logic                  w_hit_2;

    // The regfile always accepts, so a non-empty queue pops every cycle.
    assign w_pop     = (r_count != '0);
    // A slot freed by this cycle's pop is reusable by this cycle's push.
    assign w_free    = DEPTH_W - {1'b0, r_count} + {{CW{1'b0}}, w_pop};
    assign w_mem_req = mem_valid_i && (mem_addr_i != '0);
    assign w_alu_req = alu_valid_i && (alu_addr_i != '0);
    assign w_mem_acc = w_mem_req && (w_free != '0);
    assign w_alu_acc = w_alu_req && (w_mem_acc ? (w_free > (CW+1)'(1)) : (w_free != '0));
    assign w_refuse  = (w_mem_req && !w_mem_acc) || (w_alu_req && !w_alu_acc);
    // ALU entry lands behind the mem entry when both are accepted.
    assign w_alu_slot = w_mem_acc ? (r_tail + PW'(1)) : r_tail;

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_vld      <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            // Clear before set: at full with push+pop the tail slot is the head slot.
            if (w_pop)     r_vld[r_head]     <= 1'b0;
            if (w_mem_acc) r_vld[r_tail]     <= 1'b1;
            if (w_alu_acc) r_vld[w_alu_slot] <= 1'b1;
            r_head     <= r_head + PW'(w_pop);
            r_tail     <= r_tail + PW'(w_mem_acc) + PW'(w_alu_acc);
            r_count    <= r_count + CW'(w_mem_acc) + CW'(w_alu_acc) - CW'(w_pop);
            if (w_refuse) r_overflow <= 1'b1;
        end
    end

    // Payload storage; validity is tracked by r_vld so no reset is needed here.
    always_ff @(posedge clk) begin
        if (w_mem_acc) begin
            r_addr[r_tail] <= mem_addr_i;
            r_data[r_tail] <= mem_data_i;
        end
        if (w_alu_acc) begin
            r_addr[w_alu_slot] <= alu_addr_i;
            r_data[w_alu_slot] <= alu_data_i;
        end
    end

    assign wr_en_o    = w_pop;
    assign wr_addr_o  = w_pop ? r_addr[r_head] : '0;
    assign wr_data_o  = w_pop ? r_data[r_head] : '0;
    assign count_o    = r_count;
    assign overflow_o = r_overflow;
    assign full_o     = (DEPTH_W - {1'b0, r_count}) < (CW+1)'(2);

    // Match lookup includes the head entry being drained this cycle.
    always_comb begin
        logic [PW-1:0] w_idx;
        w_hit_1 = 1'b0;
        w_hit_2 = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = PW'(i);
            if (r_vld[w_idx]) begin
                if ((rd_addr_1_i != '0) && (r_addr[w_idx] == rd_addr_1_i)) w_hit_1 = 1'b1;
                if ((rd_addr_2_i != '0) && (r_addr[w_idx] == rd_addr_2_i)) w_hit_2 = 1'b1;
            end
        end
    end

`ifdef WBQ_FORWARD_EN
    logic [DATA_WIDTH-1:0] w_fwd_1;
    logic [DATA_WIDTH-1:0] w_fwd_2;

    // Walk oldest to youngest so the last match (youngest) wins.
    always_comb begin
        logic [PW-1:0] w_idx;
        w_fwd_1 = '0;
        w_fwd_2 = '0;
        w_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PW'(i);
            if (r_vld[w_idx]) begin
                if ((rd_addr_1_i != '0) && (r_addr[w_idx] == rd_addr_1_i)) w_fwd_1 = r_data[w_idx];
                if ((rd_addr_2_i != '0) && (r_addr[w_idx] == rd_addr_2_i)) w_fwd_2 = r_data[w_idx];
            end
        end
    end

    assign fwd_hit_1_o  = w_hit_1;
    assign fwd_hit_2_o  = w_hit_2;
    assign fwd_data_1_o = w_fwd_1;
    assign fwd_data_2_o = w_fwd_2;
    assign hazard_o     = 1'b0;
`else
    assign fwd_hit_1_o  = 1'b0;
    assign fwd_hit_2_o  = 1'b0;
    assign fwd_data_1_o = '0;
    assign fwd_data_2_o = '0;
    assign hazard_o     = w_hit_1 || w_hit_2;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
module tb_writeback_queue;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          reset_n_i;
    logic          mem_valid_i, alu_valid_i;
    logic [AW-1:0] mem_addr_i, alu_addr_i, rd_addr_1_i, rd_addr_2_i;
    logic [DW-1:0] mem_data_i, alu_data_i;
    logic          wr_en_o, full_o, hazard_o, overflow_o;
    logic [AW-1:0] wr_addr_o;
    logic [DW-1:0] wr_data_o;
    logic [CW-1:0] count_o;
    logic          fwd_hit_1_o, fwd_hit_2_o;
    logic [DW-1:0] fwd_data_1_o, fwd_data_2_o;

    int total = 0;
    int bad   = 0;

    // Reference model: plain in-order queue plus sticky overflow flag.
    logic [AW-1:0] qa[$];
    logic [DW-1:0] qd[$];
    bit            m_ovf;

    writeback_queue #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset_n_i(reset_n_i),
        .mem_valid_i(mem_valid_i), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
        .alu_valid_i(alu_valid_i), .alu_addr_i(alu_addr_i), .alu_data_i(alu_data_i),
        .rd_addr_1_i(rd_addr_1_i), .rd_addr_2_i(rd_addr_2_i),
        .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
        .full_o(full_o), .hazard_o(hazard_o), .overflow_o(overflow_o), .count_o(count_o),
        .fwd_hit_1_o(fwd_hit_1_o), .fwd_hit_2_o(fwd_hit_2_o),
        .fwd_data_1_o(fwd_data_1_o), .fwd_data_2_o(fwd_data_2_o)
    );

    always #5 clk = ~clk;

    task automatic set_req(input bit mv, input int ma, input int md,
                           input bit av, input int aa, input int ad);
        mem_valid_i = mv; mem_addr_i = AW'(ma); mem_data_i = DW'(md);
        alu_valid_i = av; alu_addr_i = AW'(aa); alu_data_i = DW'(ad);
    endtask

    // One clock edge; the model applies pop-then-push with mem before alu.
    task automatic tick();
        bit mv = mem_valid_i, av = alu_valid_i;
        logic [AW-1:0] ma = mem_addr_i, aa = alu_addr_i;
        logic [DW-1:0] md = mem_data_i, ad = alu_data_i;
        @(posedge clk);
        if (qa.size() > 0) begin void'(qa.pop_front()); void'(qd.pop_front()); end
        if (mv && ma != 0) begin
            if (qa.size() < DEPTH) begin qa.push_back(ma); qd.push_back(md); end
            else m_ovf = 1;
        end
        if (av && aa != 0) begin
            if (qa.size() < DEPTH) begin qa.push_back(aa); qd.push_back(ad); end
            else m_ovf = 1;
        end
        #1;
    endtask

    task automatic do_reset();
        reset_n_i = 1'b0;
        set_req(0, 0, 0, 0, 0, 0);
        rd_addr_1_i = '0; rd_addr_2_i = '0;
        qa.delete(); qd.delete(); m_ovf = 0;
        repeat (2) @(posedge clk);
        #1 reset_n_i = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        set_req(0, 0, 0, 0, 0, 0);
        rd_addr_1_i = '0; rd_addr_2_i = '0;
        #3;
        total++; if ({wr_en_o, full_o, hazard_o, overflow_o} !== 4'b0) begin bad++;
            $display("FAIL reset_flags got=%b exp=0000", {wr_en_o, full_o, hazard_o, overflow_o}); end
        total++; if (count_o !== '0) begin bad++;
            $display("FAIL reset_count got=%0d exp=0", count_o); end
        do_reset();
        total++; if (wr_en_o !== 1'b0 || wr_addr_o !== '0 || wr_data_o !== '0) begin bad++;
            $display("FAIL post_reset_wr got=%b/%0d/%h exp=0/0/0", wr_en_o, wr_addr_o, wr_data_o); end
    endtask

    task automatic test_single();
        set_req(0, 0, 0, 1, 5, 32'hDEADBEEF);
        tick();
        set_req(0, 0, 0, 0, 0, 0);
        #1;
        total++; if (wr_en_o !== 1'b1 || wr_addr_o !== 5'd5 || wr_data_o !== 32'hDEADBEEF) begin bad++;
            $display("FAIL single_head got=%b/%0d/%h exp=1/5/deadbeef", wr_en_o, wr_addr_o, wr_data_o); end
        tick();
        total++; if (wr_en_o !== 1'b0 || count_o !== '0) begin bad++;
            $display("FAIL single_drained got en=%b cnt=%0d exp en=0 cnt=0", wr_en_o, count_o); end
    endtask

    task automatic test_dual_order();
        set_req(1, 3, 32'h11, 1, 4, 32'h22);
        tick();
        set_req(0, 0, 0, 0, 0, 0);
        #1;
        total++; if (count_o !== CW'(2) || wr_addr_o !== 5'd3 || wr_data_o !== 32'h11) begin bad++;
            $display("FAIL dual_first got cnt=%0d addr=%0d data=%h exp 2/3/11", count_o, wr_addr_o, wr_data_o); end
        tick();
        total++; if (count_o !== CW'(1) || wr_addr_o !== 5'd4 || wr_data_o !== 32'h22) begin bad++;
            $display("FAIL dual_second got cnt=%0d addr=%0d data=%h exp 1/4/22", count_o, wr_addr_o, wr_data_o); end
        tick();
        total++; if (count_o !== '0 || wr_en_o !== 1'b0) begin bad++;
            $display("FAIL dual_empty got cnt=%0d en=%b exp 0/0", count_o, wr_en_o); end
    endtask

    task automatic test_zero_addr();
        set_req(1, 0, 32'h77, 1, 0, 32'h55);
        tick();
        set_req(0, 0, 0, 0, 0, 0);
        #1;
        total++; if (wr_en_o !== 1'b0 || count_o !== '0 || overflow_o !== 1'b0) begin bad++;
            $display("FAIL zero_addr got en=%b cnt=%0d ovf=%b exp 0/0/0", wr_en_o, count_o, overflow_o); end
    endtask

    task automatic test_full_overflow();
        int exp_cnt[4] = '{2, 3, 4, 4};
        for (int c = 0; c < 4; c++) begin
            set_req(1, 8 + 2*c, c, 1, 9 + 2*c, 100 + c);
            tick();
            #1;
            total++; if (count_o !== CW'(exp_cnt[c]) || full_o !== (exp_cnt[c] >= 3)) begin bad++;
                $display("FAIL full_cyc%0d got cnt=%0d full=%b exp cnt=%0d", c, count_o, full_o, exp_cnt[c]); end
            total++; if (overflow_o !== (c == 3)) begin bad++;
                $display("FAIL ovf_cyc%0d got=%b exp=%b", c, overflow_o, (c == 3)); end
        end
        set_req(0, 0, 0, 0, 0, 0);
        repeat (6) tick();
        total++; if (overflow_o !== 1'b1 || count_o !== '0) begin bad++;
            $display("FAIL ovf_sticky got ovf=%b cnt=%0d exp 1/0", overflow_o, count_o); end
        do_reset();
        total++; if (overflow_o !== 1'b0) begin bad++;
            $display("FAIL ovf_cleared got=%b exp=0", overflow_o); end
    endtask

    task automatic test_hazard();
        set_req(1, 7, 32'hA, 1, 7, 32'hB);
        tick();
        set_req(0, 0, 0, 0, 0, 0);
        rd_addr_1_i = 5'd7; rd_addr_2_i = 5'd12;
        #1;
`ifdef WBQ_FORWARD_EN
        total++; if (fwd_hit_1_o !== 1'b1 || fwd_data_1_o !== 32'hB || hazard_o !== 1'b0) begin bad++;
            $display("FAIL fwd_youngest got hit=%b data=%h haz=%b exp 1/b/0", fwd_hit_1_o, fwd_data_1_o, hazard_o); end
        total++; if (fwd_hit_2_o !== 1'b0) begin bad++;
            $display("FAIL fwd_miss got=%b exp=0", fwd_hit_2_o); end
`else
        total++; if (hazard_o !== 1'b1 || fwd_hit_1_o !== 1'b0 || fwd_data_1_o !== '0) begin bad++;
            $display("FAIL hazard_hit got haz=%b hit=%b data=%h exp 1/0/0", hazard_o, fwd_hit_1_o, fwd_data_1_o); end
`endif
        rd_addr_1_i = 5'd0; rd_addr_2_i = 5'd13;
        #1;
        total++; if (hazard_o !== 1'b0) begin bad++;
            $display("FAIL hazard_nomatch got=%b exp=0", hazard_o); end
        rd_addr_1_i = '0; rd_addr_2_i = '0;
        repeat (3) tick();
    endtask

    task automatic test_async_reset();
        set_req(1, 1, 1, 1, 2, 2);
        tick();
        set_req(1, 3, 3, 1, 4, 4);
        tick();
        set_req(0, 0, 0, 0, 0, 0);
        #1;
        total++; if (count_o !== CW'(3)) begin bad++;
            $display("FAIL pre_reset_count got=%0d exp=3", count_o); end
        reset_n_i = 1'b0;
        #1;
        total++; if (wr_en_o !== 1'b0 || count_o !== '0 || full_o !== 1'b0) begin bad++;
            $display("FAIL async_reset got en=%b cnt=%0d full=%b exp 0/0/0", wr_en_o, count_o, full_o); end
        do_reset();
    endtask

    task automatic test_random();
        bit            h1, h2, ef1, ef2, ehaz;
        logic [DW-1:0] d1, d2, efd1, efd2;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc % 130 == 129) do_reset();
            set_req($urandom_range(0, 2) != 0, $urandom_range(0, 7), $urandom,
                    $urandom_range(0, 2) != 0, $urandom_range(0, 7), $urandom);
            rd_addr_1_i = AW'($urandom_range(0, 7));
            rd_addr_2_i = AW'($urandom_range(0, 7));
            #1;
            h1 = 0; h2 = 0; d1 = '0; d2 = '0;
            foreach (qa[i]) begin
                if (rd_addr_1_i != 0 && qa[i] == rd_addr_1_i) begin h1 = 1; d1 = qd[i]; end
                if (rd_addr_2_i != 0 && qa[i] == rd_addr_2_i) begin h2 = 1; d2 = qd[i]; end
            end
`ifdef WBQ_FORWARD_EN
            ehaz = 0; ef1 = h1; ef2 = h2; efd1 = d1; efd2 = d2;
`else
            ehaz = h1 | h2; ef1 = 0; ef2 = 0; efd1 = '0; efd2 = '0;
`endif
            total++; if (wr_en_o !== (qa.size() != 0) || count_o !== CW'(qa.size())) begin bad++;
                $display("FAIL rnd_occupancy cyc=%0d got en=%b cnt=%0d exp cnt=%0d", cyc, wr_en_o, count_o, qa.size()); end
            if (qa.size() != 0) begin
                total++; if (wr_addr_o !== qa[0] || wr_data_o !== qd[0]) begin bad++;
                    $display("FAIL rnd_head cyc=%0d got %0d/%h exp %0d/%h", cyc, wr_addr_o, wr_data_o, qa[0], qd[0]); end
            end
            total++; if (full_o !== ((DEPTH - qa.size()) < 2) || overflow_o !== m_ovf) begin bad++;
                $display("FAIL rnd_status cyc=%0d got full=%b ovf=%b exp ovf=%b", cyc, full_o, overflow_o, m_ovf); end
            total++; if (hazard_o !== ehaz || fwd_hit_1_o !== ef1 || fwd_hit_2_o !== ef2) begin bad++;
                $display("FAIL rnd_hazard cyc=%0d got %b%b%b exp %b%b%b", cyc, hazard_o, fwd_hit_1_o, fwd_hit_2_o, ehaz, ef1, ef2); end
            total++; if (fwd_data_1_o !== efd1 || fwd_data_2_o !== efd2) begin bad++;
                $display("FAIL rnd_fwd_data cyc=%0d got %h/%h exp %h/%h", cyc, fwd_data_1_o, fwd_data_2_o, efd1, efd2); end
            tick();
        end
        set_req(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_dual_order();
        test_zero_addr();
        test_full_overflow();
        test_hazard();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
